padframe_io_exerciser: RTL

Parametrised successor to the fixed 10-in/10-out loopback padframe core. Sits between the `sg13g2_IOPadIn` p2c nets and the `sg13g2_IOPadOut30mA` c2p nets. Provides four output modes selected at run time:
- combinational passthrough
- synchronised, registered loopback
- binary counter pattern
- LFSR pattern

It also accumulates an input signature and an input-transition count for bring-up of the pad ring on silicon.

---
 rtl/padframe_io_pkg.sv | 20 ++
 rtl/io_sync.sv | 36 +++
 rtl/padframe_io_exerciser.sv | 111 +++++++++++
 3 files changed

// File: rtl/padframe_io_pkg.sv
// rtl/padframe_io_pkg.sv - shared types and constants for the padframe I/O exerciser
package padframe_io_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    LOOP = 2'd1,
    CNT  = 2'd2,
    LFSR = 2'd3
  } io_mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 expressed as register taps 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - multi-bit, multi-stage input synchroniser with async active-low reset
module io_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/padframe_io_exerciser.sv
// rtl/padframe_io_exerciser.sv - pad-ring bring-up core: passthrough, loopback, counter and LFSR outputs
module padframe_io_exerciser
  import padframe_io_pkg::*;
#(
  parameter int N_IO        = 10,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IO-1:0]   ui_p2c,
  output logic [N_IO-1:0]   uo_c2p,
  input  logic [1:0]        mode,
  input  logic              en,
  input  logic              stat_clr,
  output logic [N_IO-1:0]   sig,
  output logic [TCNT_W-1:0] tcnt
);

  localparam logic [N_IO-1:0]   CNT_ONE  = N_IO'(1);
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = {TCNT_W{1'b1}};

  io_mode_e          mode_q, mode_d;
  logic [N_IO-1:0]   ui_s;
  logic [N_IO-1:0]   ui_dly_q, ui_dly_d;
  logic [N_IO-1:0]   out_q, out_d;
  logic [N_IO-1:0]   cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [N_IO-1:0]   sig_q, sig_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  io_sync #(
    .WIDTH  (N_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_p2c),
    .q     (ui_s)
  );

  always_comb begin
    mode_d   = io_mode_e'(mode);
    ui_dly_d = ui_s;
    out_d    = ui_s;

    // Seed is loaded on the same edge mode_q enters the generator mode,
    // so the first cycle in the new mode always shows the seed.
    cnt_d = cnt_q;
    if (mode_d == CNT && mode_q != CNT) begin
      cnt_d = '0;
    end else if (mode_q == CNT && en) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    lfsr_d = lfsr_q;
    if (mode_d == LFSR && mode_q != LFSR) begin
      lfsr_d = LFSR_SEED;
    end else if (mode_q == LFSR && en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end

    sig_d  = sig_q;
    tcnt_d = tcnt_q;
    if (stat_clr) begin
      sig_d  = '0;
      tcnt_d = '0;
    end else if (en) begin
      sig_d = {sig_q[N_IO-2:0], sig_q[N_IO-1]} ^ ui_s;
      if (ui_s != ui_dly_q && tcnt_q != TCNT_MAX) begin
        tcnt_d = tcnt_q + TCNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= PASS;
      ui_dly_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      sig_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      ui_dly_q <= ui_dly_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      sig_q    <= sig_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    uo_c2p = ui_p2c;
    unique case (mode_q)
      PASS: uo_c2p = ui_p2c;
      LOOP: uo_c2p = out_q;
      CNT:  uo_c2p = cnt_q;
      LFSR: uo_c2p = lfsr_q[N_IO-1:0];
      default: uo_c2p = ui_p2c;
    endcase
  end

  assign sig  = sig_q;
  assign tcnt = tcnt_q;

endmodule
